// File: rtl/fifo_rr_scheduler_if.sv
// -----------------------------------------------------------------------------
// fifo_rr_scheduler_if
// Purpose : groups the handshake/bus signals between the scheduler, the
//           upstream class-FIFO bank and the downstream destination-FIFO bank.
// Params  : DATA_SIZE - word width; the 2 MSBs of a word select its destination.
// Signals : src_empty  [3:0]            empty flag per source FIFO
//           src_data   [4*DATA_SIZE-1:0] registered pop data per source,
//                                        source i at [i*DATA_SIZE +: DATA_SIZE]
//           dst_pause  [3:0]            almost-full/pause flag per destination
//           src_pop    [3:0]            one-hot pop strobe to source FIFOs
//           dst_push   [3:0]            one-hot push strobe to destination FIFOs
//           dst_data   [DATA_SIZE-1:0]  word presented with dst_push
//           grant_idx  [1:0]            source index of current/last grant
//           busy                        high while the scheduler is not idle
// Modports: slave  - the scheduler side
//           master - the FIFO-bank / environment side
// -----------------------------------------------------------------------------
interface fifo_rr_scheduler_if #(
  parameter int DATA_SIZE = 6
);
  logic [3:0]             src_empty;
  logic [4*DATA_SIZE-1:0] src_data;
  logic [3:0]             dst_pause;
  logic [3:0]             src_pop;
  logic [3:0]             dst_push;
  logic [DATA_SIZE-1:0]   dst_data;
  logic [1:0]             grant_idx;
  logic                   busy;

  modport slave (
    input  src_empty,
    input  src_data,
    input  dst_pause,
    output src_pop,
    output dst_push,
    output dst_data,
    output grant_idx,
    output busy
  );

  modport master (
    output src_empty,
    output src_data,
    output dst_pause,
    input  src_pop,
    input  dst_push,
    input  dst_data,
    input  grant_idx,
    input  busy
  );
endinterface

// File: rtl/fifo_rr_scheduler.sv
// -----------------------------------------------------------------------------
// fifo_rr_scheduler
// Purpose : moves one word per transaction from one of 4 source class FIFOs
//           into one of 4 destination FIFOs. The destination is the word's
//           2 MSBs; a paused destination stalls the transaction until it
//           frees up. Source selection is round-robin from rr_ptr.
// Macro   : SCHED_STRICT_PRIO_EN - when defined, the lowest-index non-empty
//           source always wins and rr_ptr is held at 0.
// Ports   : clk      - rising-edge clock
//           reset_L  - synchronous active-low reset
//           bus      - fifo_rr_scheduler_if.slave (see interface header)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a non-empty source; grant latched on leaving
// POP    | src_pop[grant] high for one cycle
// ROUTE  | source data valid; captured into holding register, dest decoded
// HOLD   | destination paused; re-check pause every cycle, no strobes
// PUSH   | dst_push[dest] high for one cycle with the held word
// -----------------------------------------------------------------------------
module fifo_rr_scheduler #(
  parameter int DATA_SIZE = 6,
  parameter int NUM_CH    = 4
) (
  input  logic              clk,
  input  logic              reset_L,
  fifo_rr_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_ROUTE = 3'd2,
    S_HOLD  = 3'd3,
    S_PUSH  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic [1:0]           rr_ptr_q, rr_ptr_d;
  logic [DATA_SIZE-1:0] hold_q, hold_d;

  logic                 pick_found;
  logic [1:0]           pick_idx;
  logic [1:0]           cand;
  logic [DATA_SIZE-1:0] src_word;
  logic [1:0]           route_dest;
  logic [1:0]           hold_dest;

  // Word currently offered by the granted source (valid in ROUTE).
  assign src_word   = bus.src_data[grant_q*DATA_SIZE +: DATA_SIZE];
  assign route_dest = src_word[DATA_SIZE-1 -: 2];
  assign hold_dest  = hold_q[DATA_SIZE-1 -: 2];

  // Source selection.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    cand       = 2'd0;
`ifdef SCHED_STRICT_PRIO_EN
    // Scan from the top so the lowest non-empty index is the last write.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (!bus.src_empty[k]) begin
        pick_found = 1'b1;
        pick_idx   = 2'(k);
      end
    end
`else
    // First non-empty index at or after rr_ptr, wrapping modulo 4.
    for (int k = 0; k < NUM_CH; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!pick_found && !bus.src_empty[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q  <= S_IDLE;
      grant_q  <= 2'd0;
      rr_ptr_q <= 2'd0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = S_POP;
        end
      end
      S_POP: begin
        state_d = S_ROUTE;
      end
      S_ROUTE: begin
        hold_d  = src_word;
        state_d = bus.dst_pause[route_dest] ? S_HOLD : S_PUSH;
      end
      S_HOLD: begin
        state_d = bus.dst_pause[hold_dest] ? S_HOLD : S_PUSH;
      end
      S_PUSH: begin
        // Pause is deliberately not looked at here; the push is committed.
`ifdef SCHED_STRICT_PRIO_EN
        rr_ptr_d = 2'd0;
`else
        rr_ptr_d = grant_q + 2'd1;
`endif
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from registers only, so strobes are clean.
  always_comb begin
    bus.src_pop   = 4'b0000;
    bus.dst_push  = 4'b0000;
    bus.dst_data  = hold_q;
    bus.grant_idx = grant_q;
    bus.busy      = (state_q != S_IDLE);
    if (state_q == S_POP) begin
      bus.src_pop = 4'b0001 << grant_q;
    end
    if (state_q == S_PUSH) begin
      bus.dst_push = 4'b0001 << hold_dest;
    end
  end

endmodule
